dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: core load/store unit
  - port 1: debug/DMA master
- Per accepted request it does four things:
  - translates RISC-V funct3 into a byte-enable mask and lane-aligned write data
  - sequences the one-cycle registered memory read
  - extracts and sign/zero-extends load data
  - returns one response to the requester that owns the transaction
- Sits between the requesters and the data memory.

---
 rtl/dmem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: RISC-V funct3 lane
// steering on the way in, byte/half extraction and sign/zero-extension on the way back.
module dmem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int AW        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_we,
  input  logic [1:0][2:0]      req_funct3,
  input  logic [1:0][AW-1:0]   req_addr,
  input  logic [1:0][31:0]     req_wdata,
  output logic [1:0]           resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wd,
  input  logic [31:0]          mem_rd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic misaligned;
    logic bad_type;
    misaligned = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'd0));
    bad_type   = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
    return misaligned || bad_type;
  endfunction

  function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'd0:    lanes = {4{wd[7:0]}};
      2'd1:    lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = rd;
      3'd4:    r = {24'h000000, b};
      3'd5:    r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t         state_q, state_d;
  logic           rdy_en_q;
  logic           rr_last_q, rr_last_d;
  logic           owner_q, owner_d;
  logic           we_q, we_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [1:0]     addr_lo_q, addr_lo_d;
  logic           ill_q, ill_d;
  logic           mem_we_q, mem_we_d;
  logic [3:0]     mem_be_q, mem_be_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wd_q, mem_wd_d;
  logic [1:0]     resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;

  logic [1:0]     grant;
  logic           accept;
  logic           sel;
  logic           sel_we;
  logic [2:0]     sel_f3;
  logic [AW-1:0]  sel_addr;
  logic [31:0]    sel_wdata;
  logic           sel_illegal;

  // Grant selection: a lone requester always wins; ties go by mode
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      if (PRIO_MODE == 1) begin
        grant = 2'b01;
      end else begin
        grant = rr_last_q ? 2'b01 : 2'b10;
      end
    end else begin
      grant = req_valid;
    end
  end

  // rdy_en_q keeps ready low for the first cycle after reset releases
  assign req_ready   = ((state_q == IDLE) && rdy_en_q && !reset) ? grant : 2'b00;
  assign accept      = |(req_valid & req_ready);
  assign sel         = grant[1];
  assign sel_we      = req_we[sel];
  assign sel_f3      = req_funct3[sel];
  assign sel_addr    = req_addr[sel];
  assign sel_wdata   = req_wdata[sel];
  assign sel_illegal = access_illegal(sel_we, sel_f3, sel_addr[1:0]);

  // Transaction sequencing and next values of every registered output
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    owner_d      = owner_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    ill_d        = ill_q;
    mem_we_d     = 1'b0;
    mem_be_d     = 4'b0000;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 2'b00;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = ISSUE;
          rr_last_d  = sel;
          owner_d    = sel;
          we_d       = sel_we;
          funct3_d   = sel_f3;
          addr_lo_d  = sel_addr[1:0];
          ill_d      = sel_illegal;
          // memory strobes are set up here so they are live during ISSUE
          mem_we_d   = sel_we & ~sel_illegal;
          mem_be_d   = sel_illegal ? 4'b0000 : be_mask(sel_f3, sel_addr[1:0]);
          mem_addr_d = sel_addr;
          mem_wd_d   = lane_wdata(sel_f3, sel_wdata);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d      = IDLE;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        resp_err_d   = ill_q;
        if (ill_q || we_q) begin
          resp_rdata_d = 32'h0000_0000;
        end else begin
          resp_rdata_d = load_extract(funct3_q, addr_lo_q, mem_rd);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rdy_en_q     <= 1'b0;
      rr_last_q    <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      ill_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wd_q     <= 32'h0000_0000;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      rr_last_q    <= rr_last_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      ill_q        <= ill_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance on a byte-lane memory model,
// plus a fixed-priority instance used for the contention check.
module tb_dmem_arbiter;

  logic             clk;
  logic             reset;
  logic             mem_clr;
  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;

  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic        resp_err, mem_we;
  logic [3:0]  mem_be;

  logic [1:0]  f_req_ready, f_resp_valid;
  logic [31:0] f_resp_rdata, f_mem_addr, f_mem_wd;
  logic        f_resp_err, f_mem_we;
  logic [3:0]  f_mem_be;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter #(.PRIO_MODE(0), .AW(32)) u_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.PRIO_MODE(1), .AW(32)) u_fix (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata), .resp_err(f_resp_err),
    .mem_we(f_mem_we), .mem_be(f_mem_be), .mem_addr(f_mem_addr), .mem_wd(f_mem_wd),
    .mem_rd(32'h0000_0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane data memory with a one-cycle registered read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
    mem_rd <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction starting at a negedge in IDLE; ends at the response negedge
  task automatic xact(input string tag, input int p, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic exp_mwe,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] pbit;
    pbit = (p == 0) ? 2'b01 : 2'b10;
    req_valid      = pbit;
    req_we[p]      = we;
    req_funct3[p]  = f3;
    req_addr[p]    = a;
    req_wdata[p]   = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(pbit));
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(exp_mwe));
    chk({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, ".mem_wd"}, mem_wd, exp_wd);
    chk({tag, ".mem_addr"}, mem_addr, a);
    @(negedge clk);
    chk({tag, ".cap_we"}, 32'(mem_we), 32'h0);
    chk({tag, ".cap_rv"}, 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(pbit));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    logic [1:0] g_prev, g_next;
    reset      = 1'b1;
    mem_clr    = 1'b1;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.resp_valid", 32'(resp_valid), 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err", 32'(resp_err), 32'h0);
    chk("rst.mem_we", 32'(mem_we), 32'h0);
    chk("rst.mem_be", 32'(mem_be), 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wd", mem_wd, 32'h0);
    chk("rst.f_out", {f_mem_addr[7:0], f_mem_wd[7:0], 4'(f_mem_be), 2'(f_resp_valid),
                      1'(f_mem_we), 1'(f_resp_err), f_resp_rdata[7:0]}, 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);

    xact("sw10",  0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",  0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sw20",  1, 1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b1, 4'b1111, 32'h80FF7F01, 32'h0, 1'b0);
    xact("lb23",  0, 1'b0, 3'd0, 32'h23, 32'h0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu23", 1, 1'b0, 3'd4, 32'h23, 32'h0, 1'b0, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    xact("lh22",  0, 1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0);
    xact("lhu20", 1, 1'b0, 3'd5, 32'h20, 32'h0, 1'b0, 4'b0011, 32'h0, 32'h00007F01, 1'b0);
    xact("sb31",  0, 1'b1, 3'd0, 32'h31, 32'h000000AB, 1'b1, 4'b0010, 32'hABABABAB, 32'h0, 1'b0);
    xact("sh32",  1, 1'b1, 3'd1, 32'h32, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 32'h0, 1'b0);
    xact("lw30",  0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h1234AB00, 1'b0);
    xact("sw40",  0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("sw41",  1, 1'b1, 3'd2, 32'h41, 32'h00000055, 1'b0, 4'b0000, 32'h00000055, 32'h0, 1'b1);
    xact("lw40",  0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    xact("ld3",   1, 1'b0, 3'd3, 32'h40, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact("lh21",  0, 1'b0, 3'd1, 32'h21, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact("st4",   1, 1'b1, 3'd4, 32'h40, 32'h00000077, 1'b0, 4'b0000, 32'h77777777, 32'h0, 1'b1);
    xact("lw40b", 0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);

    // Contention from a fresh reset: both ports hold valid continuously
    reset         = 1'b1;
    req_we        = 2'b00;
    req_funct3[0] = 3'd2;
    req_addr[0]   = 32'h10;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h20;
    req_valid     = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cont.first_cycle_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    chk("cont.rr_grant0", 32'(req_ready), 32'h1);
    chk("cont.fix_grant0", 32'(f_req_ready), 32'h1);
    g_prev = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("cont.rv_t1", 32'(resp_valid), 32'h0);
      @(negedge clk);
      chk("cont.rv_t2", 32'(resp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("cont.rr_resp", 32'(resp_valid), 32'(g_prev));
      chk("cont.rr_rdata", resp_rdata, (g_prev == 2'b01) ? 32'hDEADBEEF : 32'h80FF7F01);
      chk("cont.fix_resp", 32'(f_resp_valid), 32'h1);
      g_next = (k % 2 == 1) ? 2'b10 : 2'b01;
      chk("cont.rr_grant", 32'(req_ready), 32'(g_next));
      chk("cont.fix_grant", 32'(f_req_ready), 32'h1);
      g_prev = g_next;
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset during the ISSUE cycle of a port-1 store
    req_we[1]     = 1'b1;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h44;
    req_wdata[1]  = 32'h11112222;
    req_valid     = 2'b10;
    #1;
    chk("rmid.ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk("rmid.issue_we", 32'(mem_we), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rmid.mem_we", 32'(mem_we), 32'h0);
    chk("rmid.rv", 32'(resp_valid), 32'h0);
    chk("rmid.ready_in_rst", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rmid.no_resp", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    #1;
    chk("rmid.ready_release", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    chk("rmid.ready_back", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rmid.retry_we", 32'(mem_we), 32'h1);
    chk("rmid.retry_addr", mem_addr, 32'h44);
    repeat (2) @(negedge clk);
    chk("rmid.retry_resp", 32'(resp_valid), 32'h2);
    chk("rmid.retry_err", 32'(resp_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
